// File: rtl/video_dither_pkg.sv
// Shared types and helpers for the video output ditherer: channel indexing
// and the saturating add used by stage 1 of every colour channel.
package video_dither_pkg;

  localparam int NUM_CH   = 3;
  localparam int MAX_BITS = 16;
  localparam int SUM_BITS = MAX_BITS + 1;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_e;

  // Adds pixel and carried error, clamping at the all-ones value of a
  // 'bits'-wide channel so a bright pixel plus error never wraps to dark.
  function automatic logic [MAX_BITS-1:0] sat_add(input logic [MAX_BITS-1:0] a,
                                                  input logic [MAX_BITS-1:0] b,
                                                  input int bits);
    logic [SUM_BITS-1:0] s;
    logic [SUM_BITS-1:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (SUM_BITS'(1) << bits) - SUM_BITS'(1);
    return (s > lim) ? lim[MAX_BITS-1:0] : s[MAX_BITS-1:0];
  endfunction

endpackage

// File: rtl/video_dither_channel.sv
// One colour channel of the ditherer: stage-1 sum register with error
// feedback, and the stage-2 truncating output register.
module video_dither_channel
  import video_dither_pkg::*;
#(
  parameter int INBITS  = 8,
  parameter int OUTBITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INBITS-1:0]           din,
  input  logic                        vid_ena,
  input  logic                        act1,
  input  logic                        bypass,
  input  logic [INBITS-OUTBITS-1:0]   seed,
  output logic [OUTBITS-1:0]          dout
);

  localparam int F = INBITS - OUTBITS;

  logic [INBITS-1:0] s1;
  logic [INBITS-1:0] sum;
  logic [F-1:0]      err;

  // act1 is the registered vid_ena, so vid_ena & ~act1 marks the line start.
  always_comb begin
    err = '0;
    if (vid_ena) begin
      err = act1 ? s1[F-1:0] : seed;
    end
    sum = bypass ? din
                 : INBITS'(sat_add(MAX_BITS'(din), MAX_BITS'(err), INBITS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      dout <= '0;
    end else begin
      s1   <= sum;
      dout <= act1 ? s1[INBITS-1:F] : '0;
    end
  end

endmodule

// File: rtl/video_dither_pipe.sv
// Two-stage RGB ditherer with line-alternating error-diffusion seed.
// Define TEMPORAL_DITHER_EN to also alternate the seed pattern every frame.
module video_dither_pipe
  import video_dither_pkg::*;
#(
  parameter int INBITS  = 8,
  parameter int OUTBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bypass,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               vid_ena,
  input  logic [INBITS-1:0]  iRed,
  input  logic [INBITS-1:0]  iGreen,
  input  logic [INBITS-1:0]  iBlue,
  output logic [OUTBITS-1:0] oRed,
  output logic [OUTBITS-1:0] oGreen,
  output logic [OUTBITS-1:0] oBlue,
  output logic               oHsync,
  output logic               oVsync,
  output logic               oVid_ena
);

  localparam int F = INBITS - OUTBITS;
  localparam logic [F-1:0] HALF = F'(1) << (F - 1);

  logic ena_d1, ena_d2;
  logic hs_d1, hs_d2;
  logic vs_d1, vs_d2;
  logic line_par;
  logic par;
  logic vs_rise, ena_fall;
  logic [F-1:0] seed;

  logic [INBITS-1:0]  din  [NUM_CH];
  logic [OUTBITS-1:0] dout [NUM_CH];

  assign din[CH_R] = iRed;
  assign din[CH_G] = iGreen;
  assign din[CH_B] = iBlue;

  assign vs_rise  = vsync & ~vs_d1;
  assign ena_fall = ~vid_ena & ena_d1;

`ifdef TEMPORAL_DITHER_EN
  logic frame_par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_par <= 1'b0;
    end else if (vs_rise) begin
      frame_par <= ~frame_par;
    end
  end

  assign par = line_par ^ frame_par;
`else
  assign par = line_par;
`endif

  assign seed = par ? HALF : '0;

  // vsync clear takes priority over a coincident end-of-line toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_par <= 1'b0;
    end else if (vs_rise) begin
      line_par <= 1'b0;
    end else if (ena_fall) begin
      line_par <= ~line_par;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ena_d1 <= 1'b0;
      ena_d2 <= 1'b0;
      hs_d1  <= 1'b0;
      hs_d2  <= 1'b0;
      vs_d1  <= 1'b0;
      vs_d2  <= 1'b0;
    end else begin
      ena_d1 <= vid_ena;
      ena_d2 <= ena_d1;
      hs_d1  <= hsync;
      hs_d2  <= hs_d1;
      vs_d1  <= vsync;
      vs_d2  <= vs_d1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    video_dither_channel #(
      .INBITS (INBITS),
      .OUTBITS(OUTBITS)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .din    (din[g]),
      .vid_ena(vid_ena),
      .act1   (ena_d1),
      .bypass (bypass),
      .seed   (seed),
      .dout   (dout[g])
    );
  end

  assign oRed     = dout[CH_R];
  assign oGreen   = dout[CH_G];
  assign oBlue    = dout[CH_B];
  assign oHsync   = hs_d2;
  assign oVsync   = vs_d2;
  assign oVid_ena = ena_d2;

endmodule

// File: tb/tb_video_dither_pipe.sv
// Directed bench for video_dither_pipe (INBITS=8, OUTBITS=4): dithering
// pattern per line/frame, saturation, bypass, sync alignment and mid-line reset.
module tb_video_dither_pipe;

`ifdef TEMPORAL_DITHER_EN
  localparam bit TD = 1'b1;
`else
  localparam bit TD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       bypass, hsync, vsync, vid_ena;
  logic [7:0] iRed, iGreen, iBlue;
  logic [3:0] oRed, oGreen, oBlue;
  logic       oHsync, oVsync, oVid_ena;

  int n_cmp = 0;
  int n_err = 0;

  // Expected output words, {R,G,B,hsync,vsync,vid_ena}, two cycles behind input.
  logic [14:0] exp_q[$];

  video_dither_pipe #(.INBITS(8), .OUTBITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bypass  (bypass),
    .hsync   (hsync),
    .vsync   (vsync),
    .vid_ena (vid_ena),
    .iRed    (iRed),
    .iGreen  (iGreen),
    .iBlue   (iBlue),
    .oRed    (oRed),
    .oGreen  (oGreen),
    .oBlue   (oBlue),
    .oHsync  (oHsync),
    .oVsync  (oVsync),
    .oVid_ena(oVid_ena)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] out_word();
    return {oRed, oGreen, oBlue, oHsync, oVsync, oVid_ena};
  endfunction

  // 0x08 per pixel: seed 0 gives 0,1,0,1...; seed 8 gives 1,0,1,0...
  function automatic logic [3:0] alt(input bit s, input int i);
    return (((i % 2) == 1) ^ s) ? 4'h1 : 4'h0;
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic px(input string tag,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic ena, input logic hs, input logic vs, input logic byp,
                    input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    logic [14:0] e;
    iRed = r; iGreen = g; iBlue = b;
    vid_ena = ena; hsync = hs; vsync = vs; bypass = byp;
    exp_q.push_back({er, eg, eb, hs, vs, ena});
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check(tag, out_word(), e);
    end
  endtask

  task automatic blank(input string tag, input logic hs, input logic vs);
    px(tag, 8'h55, 8'hAA, 8'h33, 1'b0, hs, vs, 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    bypass = 1'b0; hsync = 1'b0; vsync = 1'b0; vid_ena = 1'b0;
    iRed = 8'h00; iGreen = 8'h00; iBlue = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", out_word(), 15'h0);
    #3 reset = 1'b0;

    // Frame 0, line 0 (seed 0); green 0xFF saturates, blue 0 stays 0.
    for (int i = 0; i < 4; i++)
      px("f0_line0", 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, alt(1'b0, i), 4'hF, 4'h0);
    blank("hs_pulse0", 1'b1, 1'b0);
    blank("blank0", 1'b0, 1'b0);

    // Frame 0, line 1 (seed 8); green 0xFF + 8 clamps, stays 0xF.
    for (int i = 0; i < 4; i++)
      px("f0_line1", 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, alt(1'b1, i), 4'hF, 4'h0);
    blank("hs_pulse1", 1'b1, 1'b0);
    blank("blank1", 1'b0, 1'b0);
    blank("vs_pulse", 1'b0, 1'b1);
    blank("blank2", 1'b0, 1'b0);

    // Frame 1, line 0: line parity cleared by vsync; frame parity flips the seed if enabled.
    for (int i = 0; i < 4; i++)
      px("f1_line0", 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, alt(TD, i), 4'hF, 4'h0);
    blank("hs_pulse2", 1'b1, 1'b0);

    // Bypass on two lines of opposite parity: plain truncation.
    for (int i = 0; i < 4; i++)
      px("bypass_a", 8'h8F, 8'hFF, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 4'hF, 4'h0);
    blank("blank3", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      px("bypass_b", 8'h8F, 8'hFF, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 4'hF, 4'h0);
    blank("blank4", 1'b1, 1'b0);

    // Line with parity 1, interrupted by reset after two pixels.
    for (int i = 0; i < 2; i++)
      px("pre_reset", 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, alt(1'b1 ^ TD, i), 4'hF, 4'h0);
    #2 reset = 1'b1;
    #1;
    check("reset_async", out_word(), 15'h0);
    exp_q.delete();
    vid_ena = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", out_word(), 15'h0);
    #3 reset = 1'b0;

    // After release line parity is 0 again; first output lands 2 cycles after input.
    px("post_reset", 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, alt(1'b0, 0), 4'hF, 4'h0);
    check("post_reset_gap", out_word(), 15'h0);
    for (int i = 1; i < 4; i++)
      px("post_reset", 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, alt(1'b0, i), 4'hF, 4'h0);
    blank("hs_pulse3", 1'b1, 1'b0);
    blank("drain", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
